// File: rtl/otp_decryptor.sv
// ---------------------------------------------------------------------------
// otp_decryptor
//   Receive-side one-time-pad decryptor. A DEPTH-entry pad store is filled
//   from the pad stream. Each tagged ciphertext byte is XORed with the pad in
//   its slot. The pad is burned on use, so a second use of the same slot
//   yields an error result.
//
// Ports
//   clk, rst         system clock; synchronous active-high reset
//   ena              block enable; low stops new pad/ciphertext acceptance
//   pad_valid/ready  pad write stream (pad_idx, pad_data)
//   ct_valid/ready   ciphertext stream (ct_idx, ct_data)
//   pt_valid/ready   plaintext result stream (pt_data, pt_idx, pt_err)
//   slot_valid       per-slot "pad loaded, unused" flags
//   err_cnt          saturating count of error results
// ---------------------------------------------------------------------------
module otp_decryptor #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              pad_valid,
  output logic              pad_ready,
  input  logic [IDX_W-1:0]  pad_idx,
  input  logic [DATA_W-1:0] pad_data,
  input  logic              ct_valid,
  output logic              ct_ready,
  input  logic [IDX_W-1:0]  ct_idx,
  input  logic [DATA_W-1:0] ct_data,
  output logic              pt_valid,
  input  logic              pt_ready,
  output logic [DATA_W-1:0] pt_data,
  output logic [IDX_W-1:0]  pt_idx,
  output logic              pt_err,
  output logic [DEPTH-1:0]  slot_valid,
  output logic [7:0]        err_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  ct_idx_p0;
  logic [DATA_W-1:0] ct_data_p0;

  logic              pad_fire;
  logic              ct_fire;
  logic              slot_hit;
  logic [DATA_W-1:0] pad_rd;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign pad_ready = ena;
  assign ct_ready  = ena & (state == IDLE);
  assign pad_fire  = pad_valid & pad_ready;
  assign ct_fire   = ct_valid & ct_ready;

  // Registered values, so this reflects the store before any same-cycle pad write.
  assign slot_hit  = slot_valid[ct_idx_p0];
  assign pad_rd    = mem[ct_idx_p0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ct_fire) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = HOLD;
      HOLD:    if (pt_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---- stage p0: capture accepted ciphertext ----
  always_ff @(posedge clk) begin
    if (ct_fire) begin
      ct_idx_p0  <= ct_idx;
      ct_data_p0 <= ct_data;
    end
  end

  // Burn comes first so that a same-cycle pad write to that slot wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (state == LOOKUP && slot_hit) slot_valid[ct_idx_p0] <= 1'b0;
      if (pad_fire) begin
        mem[pad_idx]        <= pad_data;
        slot_valid[pad_idx] <= 1'b1;
      end
    end
  end

  // ---- stage p1: lookup, decrypt and hold result ----
  always_ff @(posedge clk) begin
    if (rst) begin
      pt_valid <= 1'b0;
      pt_data  <= '0;
      pt_idx   <= '0;
      pt_err   <= 1'b0;
      err_cnt  <= '0;
    end else if (state == LOOKUP) begin
      pt_valid <= 1'b1;
      pt_idx   <= ct_idx_p0;
      if (slot_hit) begin
        pt_data <= pad_rd ^ ct_data_p0;
        pt_err  <= 1'b0;
      end else begin
        pt_data <= '0;
        pt_err  <= 1'b1;
        err_cnt <= sat_inc(err_cnt);
      end
    end else if (state == HOLD && pt_ready) begin
      pt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_otp_decryptor.sv
module tb_otp_decryptor;

  logic       clk = 1'b0;
  logic       rst, ena;
  logic       pad_valid, pad_ready;
  logic [2:0] pad_idx;
  logic [7:0] pad_data;
  logic       ct_valid, ct_ready;
  logic [2:0] ct_idx;
  logic [7:0] ct_data;
  logic       pt_valid, pt_ready;
  logic [7:0] pt_data;
  logic [2:0] pt_idx;
  logic       pt_err;
  logic [7:0] slot_valid;
  logic [7:0] err_cnt;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  otp_decryptor #(.DATA_W(8), .DEPTH(8), .IDX_W(3)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .pad_valid(pad_valid), .pad_ready(pad_ready), .pad_idx(pad_idx), .pad_data(pad_data),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_idx(ct_idx), .ct_data(ct_data),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data), .pt_idx(pt_idx),
    .pt_err(pt_err), .slot_valid(slot_valid), .err_cnt(err_cnt)
  );

  typedef struct {
    bit         load;
    logic [2:0] pidx;
    logic [7:0] pdata;
    logic [2:0] cidx;
    logic [7:0] cdata;
    logic [7:0] exp_data;
    logic       exp_err;
    logic [7:0] exp_slots;
    logic [7:0] exp_errs;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_pad(input logic [2:0] idx, input logic [7:0] data);
    @(negedge clk);
    pad_valid = 1'b1; pad_idx = idx; pad_data = data;
    @(posedge clk);
    @(negedge clk);
    pad_valid = 1'b0;
  endtask

  // Returns at the negedge following the accepting edge (DUT in LOOKUP).
  task automatic accept_ct(input logic [2:0] idx, input logic [7:0] data);
    @(negedge clk);
    ct_valid = 1'b1; ct_idx = idx; ct_data = data;
    @(posedge clk);
    @(negedge clk);
    ct_valid = 1'b0;
  endtask

  // Full decrypt with pt_ready high: result visible one edge after LOOKUP.
  task automatic run_ct(input string tag, input logic [2:0] idx, input logic [7:0] data,
                        input logic [7:0] exp_data, input logic exp_err);
    accept_ct(idx, data);
    @(posedge clk); @(negedge clk);
    check({tag, " pt_valid"}, 32'(pt_valid), 32'd1);
    check({tag, " pt_data"},  32'(pt_data),  32'(exp_data));
    check({tag, " pt_idx"},   32'(pt_idx),   32'(idx));
    check({tag, " pt_err"},   32'(pt_err),   32'(exp_err));
    @(posedge clk); @(negedge clk);
    check({tag, " pt_valid drop"}, 32'(pt_valid), 32'd0);
  endtask

  initial begin
    tbl[0] = '{1, 3'd3, 8'hA5, 3'd3, 8'h5A, 8'hFF, 1'b0, 8'h00, 8'd0};
    tbl[1] = '{0, 3'd0, 8'h00, 3'd3, 8'h12, 8'h00, 1'b1, 8'h00, 8'd1};
    tbl[2] = '{1, 3'd5, 8'h3C, 3'd5, 8'h3C, 8'h00, 1'b0, 8'h00, 8'd1};
    tbl[3] = '{1, 3'd7, 8'hC3, 3'd7, 8'h0F, 8'hCC, 1'b0, 8'h00, 8'd1};
    tbl[4] = '{1, 3'd1, 8'h81, 3'd2, 8'h55, 8'h00, 1'b1, 8'h02, 8'd2};
    tbl[5] = '{0, 3'd0, 8'h00, 3'd1, 8'h18, 8'h99, 1'b0, 8'h00, 8'd2};
    tbl[6] = '{1, 3'd4, 8'h11, 3'd6, 8'h00, 8'h00, 1'b1, 8'h10, 8'd3};
    tbl[7] = '{1, 3'd4, 8'h22, 3'd4, 8'h66, 8'h44, 1'b0, 8'h00, 8'd3};

    rst = 1'b1; ena = 1'b1; pt_ready = 1'b1;
    pad_valid = 1'b0; pad_idx = '0; pad_data = '0;
    ct_valid = 1'b0; ct_idx = '0; ct_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset pt_valid",   32'(pt_valid),   32'd0);
    check("reset slot_valid", 32'(slot_valid), 32'd0);
    check("reset err_cnt",    32'(err_cnt),    32'd0);
    check("reset ct_ready",   32'(ct_ready),   32'd1);
    check("reset pad_ready",  32'(pad_ready),  32'd1);

    // Table: optional pad load, one decrypt, then store/counter state.
    for (int i = 0; i < 8; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      if (tbl[i].load) begin
        do_pad(tbl[i].pidx, tbl[i].pdata);
        check({tag, " slot loaded"}, 32'(slot_valid[tbl[i].pidx]), 32'd1);
      end
      run_ct(tag, tbl[i].cidx, tbl[i].cdata, tbl[i].exp_data, tbl[i].exp_err);
      check({tag, " slot_valid"}, 32'(slot_valid), 32'(tbl[i].exp_slots));
      check({tag, " err_cnt"},    32'(err_cnt),    32'(tbl[i].exp_errs));
    end

    // Backpressure: result held stable, no new ciphertext accepted.
    do_pad(3'd2, 8'h40);
    pt_ready = 1'b0;
    accept_ct(3'd2, 8'h04);
    check("bp latency pt_valid", 32'(pt_valid), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); @(negedge clk);
      check("bp pt_valid", 32'(pt_valid), 32'd1);
      check("bp pt_data",  32'(pt_data),  32'h44);
      check("bp pt_idx",   32'(pt_idx),   32'd2);
      check("bp ct_ready", 32'(ct_ready), 32'd0);
    end
    pt_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("bp release pt_valid", 32'(pt_valid), 32'd0);
    check("bp release ct_ready", 32'(ct_ready), 32'd1);
    check("bp pt_data kept",     32'(pt_data),  32'h44);

    // Collision: pad write to the slot being burned during LOOKUP.
    do_pad(3'd0, 8'h0F);
    accept_ct(3'd0, 8'hF0);
    pad_valid = 1'b1; pad_idx = 3'd0; pad_data = 8'h33;
    @(posedge clk); @(negedge clk);
    pad_valid = 1'b0;
    check("coll pt_data",    32'(pt_data),       32'hFF);
    check("coll pt_err",     32'(pt_err),        32'd0);
    check("coll slot0",      32'(slot_valid[0]), 32'd1);
    @(posedge clk); @(negedge clk);
    run_ct("coll newpad", 3'd0, 8'h00, 8'h33, 1'b0);
    check("coll err_cnt", 32'(err_cnt), 32'd3);

    // ena low: nothing accepted.
    @(negedge clk);
    ena = 1'b0;
    ct_valid = 1'b1; ct_idx = 3'd6; ct_data = 8'h00;
    pad_valid = 1'b1; pad_idx = 3'd6; pad_data = 8'h77;
    #1;
    check("ena0 ct_ready",  32'(ct_ready),  32'd0);
    check("ena0 pad_ready", 32'(pad_ready), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ena0 slot_valid", 32'(slot_valid), 32'd0);
    check("ena0 pt_valid",   32'(pt_valid),   32'd0);
    ct_valid = 1'b0; pad_valid = 1'b0; ena = 1'b1;
    // In-flight ciphertext completes after ena drops.
    accept_ct(3'd6, 8'h00);
    ena = 1'b0;
    @(posedge clk); @(negedge clk);
    check("ena0 inflight pt_valid", 32'(pt_valid), 32'd1);
    check("ena0 inflight pt_err",   32'(pt_err),   32'd1);
    check("ena0 inflight err_cnt",  32'(err_cnt),  32'd4);
    check("ena0 inflight ct_ready", 32'(ct_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    check("ena0 handshake pt_valid", 32'(pt_valid), 32'd0);
    ena = 1'b1;

    // Saturation of err_cnt.
    do_pad(3'd1, 8'h5A);
    for (int n = 0; n < 260; n++) begin
      accept_ct(3'd5, 8'h00);
      @(posedge clk); @(posedge clk); @(negedge clk);
    end
    check("sat err_cnt",    32'(err_cnt),    32'd255);
    check("sat slot_valid", 32'(slot_valid), 32'h02);

    // Reset during HOLD.
    pt_ready = 1'b0;
    accept_ct(3'd5, 8'h00);
    @(posedge clk); @(negedge clk);
    check("hold pt_valid", 32'(pt_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("rst hold pt_valid",   32'(pt_valid),   32'd0);
    check("rst hold err_cnt",    32'(err_cnt),    32'd0);
    check("rst hold slot_valid", 32'(slot_valid), 32'd0);
    check("rst hold pt_err",     32'(pt_err),     32'd0);
    check("rst hold ct_ready",   32'(ct_ready),   32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
